run_controller: RTL and testbench

Sequences the single-cycle MIPS `computer` through a controlled test run: it holds the CPU in reset, releases it, and gates its clock enable. It then watches the data-memory write bus for a completion store, or stops the run on a cycle timeout. It sits between the `clock` module and `computer`: it drives `computer.reset` and the clock `ENABLE`, and snoops `memwrite`/`dataadr`/`writedata`. Its `done`/`timeout`/`cycles` outputs replace ad-hoc pass/fail logic in benches and board tops.

---
 rtl/run_controller.sv | 90 +++++++++
 tb/tb_run_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// Test-run sequencer for the single-cycle MIPS computer: holds the CPU in reset,
// runs it, and stops on a completion store or a cycle timeout.
module run_controller #(
   parameter int          n            = 32,
   parameter int          RESET_CYCLES = 4,
   parameter int          TIMEOUT      = 1024,
   parameter int          DONE_ADDR    = 21,
   parameter logic [n-1:0] DONE_DATA   = 32'h00000096
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         abort,
   input  logic         memwrite,
   input  logic [n-1:0] dataadr,
   input  logic [n-1:0] writedata,
   output logic         cpu_reset,
   output logic         cpu_en,
   output logic         busy,
   output logic         done,
   output logic         timeout,
   output logic [31:0]  cycles
);

   typedef enum logic [2:0] {
      IDLE,
      RESET_HOLD,
      RUN,
      DONE,
      FAIL
   } state_t;

   localparam logic [n-1:0] ADDR_C = n'(DONE_ADDR);
   localparam logic [31:0]  HOLD_LAST = 32'(RESET_CYCLES - 1);
   localparam logic [31:0]  TMO_LAST = 32'(TIMEOUT - 1);

   state_t      state_q;
   logic [31:0] hold_q;
   logic [31:0] cycles_q;
   logic        match;

   // X/Z on any compared bit makes this unknown, which the if treats as false
   assign match = memwrite && (dataadr == ADDR_C) &&
                  (writedata == DONE_DATA);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         hold_q   <= '0;
         cycles_q <= '0;
      end else begin
         unique case (state_q)
            IDLE, DONE, FAIL: begin
               if (start) begin
                  state_q  <= RESET_HOLD;
                  hold_q   <= '0;
                  cycles_q <= '0;
               end
            end
            RESET_HOLD: begin
               hold_q <= hold_q + 32'd1;
               if (abort) begin
                  state_q <= IDLE;
               end else if (hold_q == HOLD_LAST) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               cycles_q <= cycles_q + 32'd1;
               if (abort) begin
                  state_q <= IDLE;
               end else if (match) begin
                  state_q <= DONE;
               end else if (cycles_q == TMO_LAST) begin
                  state_q <= FAIL;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cpu_reset = (state_q == IDLE) || (state_q == RESET_HOLD);
   assign cpu_en    = (state_q == RESET_HOLD) || (state_q == RUN);
   assign busy      = (state_q == RESET_HOLD) || (state_q == RUN);
   assign done      = (state_q == DONE);
   assign timeout   = (state_q == FAIL);
   assign cycles    = cycles_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed self-checking bench for run_controller with
// RESET_CYCLES=4 and TIMEOUT=16.
module tb_run_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic        cpu_reset;
   logic        cpu_en;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [31:0] cycles;

   int checks = 0;
   int errors = 0;

   localparam logic [4:0] S_IDLE = 5'b10000;
   localparam logic [4:0] S_HOLD = 5'b11100;
   localparam logic [4:0] S_RUN  = 5'b01100;
   localparam logic [4:0] S_DONE = 5'b00010;
   localparam logic [4:0] S_FAIL = 5'b00001;

   run_controller #(
      .RESET_CYCLES(4),
      .TIMEOUT(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .abort(abort),
      .memwrite(memwrite),
      .dataadr(dataadr),
      .writedata(writedata),
      .cpu_reset(cpu_reset),
      .cpu_en(cpu_en),
      .busy(busy),
      .done(done),
      .timeout(timeout),
      .cycles(cycles)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_st(input string tag, input logic [4:0] exp);
      logic [4:0] obs;
      obs = {cpu_reset, cpu_en, busy, done, timeout};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s outputs got %b exp %b", tag, obs, exp);
      end
   endtask

   task automatic chk_cy(input string tag, input logic [31:0] exp);
      checks++;
      assert (cycles === exp) else begin
         errors++;
         $error("FAIL %s cycles got %0d exp %0d", tag, cycles, exp);
      end
   endtask

   task automatic no_store;
      memwrite  = 1'b0;
      dataadr   = 32'd0;
      writedata = 32'd0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      memwrite  = 1'b1;
      dataadr   = a;
      writedata = d;
   endtask

   // Pulse start and advance to RUN cycle 1
   task automatic begin_run;
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (4) tick;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      no_store;
      repeat (3) tick;
      reset = 1'b0;
      tick;
      chk_st("idle_after_reset", S_IDLE);
      chk_cy("idle_cycles", 32'd0);

      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk_st("abort_in_idle_ignored", S_IDLE);

      start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_st($sformatf("hold_%0d", i), S_HOLD);
         tick;
      end
      chk_st("run_first", S_RUN);
      chk_cy("run_first_cycles", 32'd0);

      repeat (6) tick;
      chk_st("run_7", S_RUN);
      chk_cy("run_7_cycles", 32'd6);
      store(32'd21, 32'h96);
      tick;
      no_store;
      chk_st("done_on_7", S_DONE);
      chk_cy("done_cycles", 32'd7);
      tick;
      chk_st("done_sticky", S_DONE);
      chk_cy("done_cycles_hold", 32'd7);
      start = 1'b1;
      tick;
      start = 1'b0;
      chk_st("restart_from_done", S_HOLD);
      chk_cy("restart_clears", 32'd0);
      repeat (4) tick;
      chk_st("restart_run", S_RUN);

      store(32'd21, 32'h95);
      tick;
      memwrite = 1'b0;
      dataadr = 32'd21;
      writedata = 32'h96;
      tick;
      store(32'd22, 32'h96);
      tick;
      store(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      tick;
      no_store;
      repeat (11) tick;
      chk_st("run_16_pre_tmo", S_RUN);
      chk_cy("run_16_cycles", 32'd15);
      tick;
      chk_st("timeout", S_FAIL);
      chk_cy("timeout_cycles", 32'd16);
      tick;
      chk_st("timeout_sticky", S_FAIL);
      chk_cy("timeout_cycles_hold", 32'd16);

      begin_run;
      repeat (15) tick;
      chk_cy("edge_pre", 32'd15);
      store(32'd21, 32'h96);
      tick;
      no_store;
      chk_st("match_beats_timeout", S_DONE);
      chk_cy("match_beats_cycles", 32'd16);

      begin_run;
      repeat (2) tick;
      abort = 1'b1;
      store(32'd21, 32'h96);
      tick;
      abort = 1'b0;
      no_store;
      chk_st("abort_run", S_IDLE);
      chk_cy("abort_cycles", 32'd3);

      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk_st("abort_hold", S_IDLE);
      chk_cy("abort_hold_cycles", 32'd0);

      begin_run;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk_st("start_ignored_run", S_RUN);
      chk_cy("start_ignored_cycles", 32'd1);
      memwrite = 1'b1;
      dataadr = 32'bx;
      writedata = 32'h96;
      tick;
      no_store;
      chk_st("x_addr_no_match", S_RUN);
      chk_cy("x_addr_cycles", 32'd2);
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk_st("reset_mid_run", S_IDLE);
      chk_cy("reset_mid_cycles", 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
